// File: rtl/ahb_matrix_pkg.sv
// ahb_matrix_pkg
//   Shared AHB-lite definitions for the bus matrix input stages, output stages
//   and per-slave arbiters.
//   - htrans_t : HTRANS transfer type codes
//   - hburst_t : HBURST burst type codes
//   - burst_beats(hburst) : number of beats of a fixed-length burst,
//     0 for undefined-length INCR
package ahb_matrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    localparam int BURST_CNT_W = 4;

    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        beats = 5'd0;
        case (hburst)
            HBURST_SINGLE:               beats = 5'd1;
            HBURST_INCR:                 beats = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4: beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8: beats = 5'd8;
            default:                     beats = 5'd16;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arb_burst_cnt.sv
// ahb_arb_burst_cnt
//   Tracks the burst in progress on one matrix output stage so the arbiter
//   never moves the grant in the middle of a burst.
//   Ports:
//     HCLK, HRESETn   clock, asynchronous active-low reset
//     HREADY          slave HREADYOUT; all state advances only when high
//     HTRANS, HBURST  transfer type / burst type of the selected port
//     grant_new       arbiter is handing the slave to a different port
//     hold            1 = arbitration must not happen on this HREADY edge
//     burst_hold      registered status: a burst is currently in progress
//   Fixed-length bursts use a 4-bit beat down-counter; undefined-length INCR
//   uses a flag that stays set through SEQ/BUSY beats.
module ahb_arb_burst_cnt
    import ahb_matrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       grant_new,
    output logic       hold,
    output logic       burst_hold
);

    logic [BURST_CNT_W-1:0] cnt;
    logic [BURST_CNT_W-1:0] cnt_nxt;
    logic                   incr;
    logic                   incr_nxt;
    logic [4:0]             beats;
    logic                   hold_nxt;

    always_comb begin
        beats    = burst_beats(HBURST);
        cnt_nxt  = cnt;
        incr_nxt = incr;
        case (HTRANS)
            HTRANS_NONSEQ: begin
                // every NONSEQ starts a new burst; SINGLE loads 0 (no hold)
                if (beats == 5'd0) begin
                    cnt_nxt  = '0;
                    incr_nxt = 1'b1;
                end else begin
                    cnt_nxt  = BURST_CNT_W'(beats - 5'd1);
                    incr_nxt = 1'b0;
                end
            end
            HTRANS_SEQ: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HTRANS_BUSY: begin
                // master paused inside the burst: keep everything
            end
            default: begin
                // IDLE terminates any burst, counted or INCR
                cnt_nxt  = '0;
                incr_nxt = 1'b0;
            end
        endcase
        hold_nxt = (cnt_nxt != '0) | incr_nxt;
    end

    // hold looks at the state after this edge so the last SEQ beat, an early
    // IDLE or an INCR-ending NONSEQ re-arbitrates in the same cycle
    assign hold       = HREADY ? hold_nxt : burst_hold;
    assign burst_hold = (cnt != '0) | incr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt  <= '0;
            incr <= 1'b0;
        end else if (HREADY) begin
            if (grant_new) begin
                // burst state belongs to the previous owner
                cnt  <= '0;
                incr <= 1'b0;
            end else begin
                cnt  <= cnt_nxt;
                incr <= incr_nxt;
            end
        end
    end

endmodule

// File: rtl/ahb_matrix_arbiter_nport.sv
// ahb_matrix_arbiter_nport
//   Per-slave arbiter for the AHB-lite bus matrix output stage. Selects one
//   of NUM_PORTS masters, changing the selection only on HREADY_out and never
//   inside a fixed-length or active INCR burst. One instance per slave port.
//   Build option: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin search starting at last granted port + 1
//     undefined -> fixed priority, port 0 highest; no pointer register
//   Ports:
//     HCLK, HRESETn  clock, asynchronous active-low reset
//     req            per-port level request from the input stages
//     HREADY_out     HREADYOUT of the slave behind this output stage
//     HSEL_out       output-stage HSEL of the selected port
//     HTRANS_out     output-stage HTRANS of the selected port
//     HBURST_out     output-stage HBURST of the selected port
//     port_sel       0 = no port, k+1 = port k granted
//     port_nosel     1 = no port selected, output stage drives IDLE
//     burst_hold     1 = grant frozen by an ongoing burst
module ahb_matrix_arbiter_nport
    import ahb_matrix_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int SEL_W     = $clog2(NUM_PORTS + 1)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 HREADY_out,
    input  logic                 HSEL_out,
    input  logic [1:0]           HTRANS_out,
    input  logic [2:0]           HBURST_out,
    output logic [SEL_W-1:0]     port_sel,
    output logic                 port_nosel,
    output logic                 burst_hold
);

    logic             hold;
    logic             arb_en;
    logic             grant_new;
    logic [SEL_W-1:0] win_code;

    ahb_arb_burst_cnt u_burst_cnt (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HREADY     (HREADY_out),
        .HTRANS     (HTRANS_out),
        .HBURST     (HBURST_out),
        .grant_new  (grant_new),
        .hold       (hold),
        .burst_hold (burst_hold)
    );

    assign arb_en    = HREADY_out & ~hold;
    assign grant_new = arb_en & (win_code != port_sel);

`ifdef ARB_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       rr_ptr_nxt;
    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    int                     win_idx;

    // rotate req so the pointer port sits at bit 0, then take the lowest bit
    always_comb begin
        req_dbl  = {req, req} >> rr_ptr;
        req_rot  = req_dbl[NUM_PORTS-1:0];
        win_code = '0;
        win_idx  = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_idx = int'(rr_ptr) + i;
                if (win_idx >= NUM_PORTS) begin
                    win_idx = win_idx - NUM_PORTS;
                end
                win_code = SEL_W'(win_idx + 1);
            end
        end
        // winner k -> pointer (k+1) mod NUM_PORTS; win_code already holds k+1
        rr_ptr_nxt = (int'(win_code) >= NUM_PORTS) ? '0 : PTR_W'(win_code);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr <= '0;
        end else if (arb_en && (|req)) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`else
    always_comb begin
        win_code = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_code = SEL_W'(i + 1);
            end
        end
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            port_sel   <= '0;
            port_nosel <= 1'b1;
        end else if (arb_en) begin
            port_sel   <= win_code;
            port_nosel <= ~(|req) & ~HSEL_out;
        end
    end

endmodule

// File: tb/tb_ahb_matrix_arbiter_nport.sv
// tb_ahb_matrix_arbiter_nport
//   Directed bench for ahb_matrix_arbiter_nport with NUM_PORTS=3. Expected
//   values are hand-derived; the few that depend on ARB_ROUND_ROBIN_EN are
//   selected with the same macro.
module tb_ahb_matrix_arbiter_nport;
    import ahb_matrix_pkg::*;

    localparam int NUM_PORTS = 3;
    localparam int SEL_W     = $clog2(NUM_PORTS + 1);

    logic                 HCLK;
    logic                 HRESETn;
    logic [NUM_PORTS-1:0] req;
    logic                 HREADY_out;
    logic                 HSEL_out;
    logic [1:0]           HTRANS_out;
    logic [2:0]           HBURST_out;
    logic [SEL_W-1:0]     port_sel;
    logic                 port_nosel;
    logic                 burst_hold;

    int checks   = 0;
    int failures = 0;
    int exp_111;
    int exp_seq [5];

    ahb_matrix_arbiter_nport #(.NUM_PORTS(NUM_PORTS)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req        (req),
        .HREADY_out (HREADY_out),
        .HSEL_out   (HSEL_out),
        .HTRANS_out (HTRANS_out),
        .HBURST_out (HBURST_out),
        .port_sel   (port_sel),
        .port_nosel (port_nosel),
        .burst_hold (burst_hold)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_111 = 3;
        exp_seq = '{1, 2, 3, 1, 2};
`else
        exp_111 = 1;
        exp_seq = '{1, 1, 1, 1, 1};
`endif
        HRESETn    = 1'b0;
        req        = '0;
        HREADY_out = 1'b1;
        HSEL_out   = 1'b0;
        HTRANS_out = HTRANS_IDLE;
        HBURST_out = HBURST_SINGLE;
        tick();
        tick();
        chk("rst_sel",   32'(port_sel),   0);
        chk("rst_nosel", 32'(port_nosel), 1);
        chk("rst_hold",  32'(burst_hold), 0);

        HRESETn = 1'b1;
        tick();
        chk("noreq_sel",   32'(port_sel),   0);
        chk("noreq_nosel", 32'(port_nosel), 1);

        // arbitration without bursts
        req = 3'b110;
        tick();
        chk("arb_110_sel",   32'(port_sel),   2);
        chk("arb_110_nosel", 32'(port_nosel), 0);
        req = 3'b111;
        tick();
        chk("arb_111_sel", 32'(port_sel), 32'(exp_111));
        req = 3'b100;
        tick();
        chk("arb_100_sel", 32'(port_sel), 3);

        // INCR4 from port 2 while port 0 starts requesting
        HSEL_out   = 1'b1;
        HTRANS_out = HTRANS_NONSEQ;
        HBURST_out = HBURST_INCR4;
        req        = 3'b101;
        tick();
        chk("incr4_b1_sel",  32'(port_sel),   3);
        chk("incr4_b1_hold", 32'(burst_hold), 1);
        HTRANS_out = HTRANS_SEQ;
        tick();
        chk("incr4_b2_sel", 32'(port_sel), 3);
        tick();
        chk("incr4_b3_sel",  32'(port_sel),   3);
        chk("incr4_b3_hold", 32'(burst_hold), 1);
        tick();
        chk("incr4_b4_sel",  32'(port_sel),   1);
        chk("incr4_b4_hold", 32'(burst_hold), 0);

        // INCR8 from port 0 with a 5-cycle HREADY stall after beat 4
        req        = 3'b001;
        HTRANS_out = HTRANS_NONSEQ;
        HBURST_out = HBURST_INCR8;
        tick();
        chk("incr8_b1_hold", 32'(burst_hold), 1);
        req        = 3'b010;
        HTRANS_out = HTRANS_SEQ;
        tick();
        tick();
        tick();
        chk("incr8_b4_sel", 32'(port_sel), 1);
        HREADY_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_sel",  32'(port_sel),   1);
            chk("stall_hold", 32'(burst_hold), 1);
        end
        HREADY_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("incr8_b567_sel", 32'(port_sel), 1);
        end
        tick();
        chk("incr8_b8_sel",  32'(port_sel),   2);
        chk("incr8_b8_hold", 32'(burst_hold), 0);

        // INCR4 from port 1 aborted by IDLE after two beats
        req        = 3'b011;
        HTRANS_out = HTRANS_NONSEQ;
        HBURST_out = HBURST_INCR4;
        tick();
        chk("abort_b1_sel", 32'(port_sel), 2);
        HTRANS_out = HTRANS_SEQ;
        tick();
        chk("abort_b2_sel",  32'(port_sel),   2);
        chk("abort_b2_hold", 32'(burst_hold), 1);
        HTRANS_out = HTRANS_IDLE;
        tick();
        chk("abort_idle_sel",  32'(port_sel),   1);
        chk("abort_idle_hold", 32'(burst_hold), 0);

        // undefined-length INCR from port 0: NONSEQ, BUSY, SEQ, then NONSEQ
        req        = 3'b010;
        HTRANS_out = HTRANS_NONSEQ;
        HBURST_out = HBURST_INCR;
        tick();
        chk("incr_ns_sel",  32'(port_sel),   1);
        chk("incr_ns_hold", 32'(burst_hold), 1);
        HTRANS_out = HTRANS_BUSY;
        tick();
        chk("incr_busy_sel",  32'(port_sel),   1);
        chk("incr_busy_hold", 32'(burst_hold), 1);
        HTRANS_out = HTRANS_SEQ;
        tick();
        chk("incr_seq_sel", 32'(port_sel), 1);
        HTRANS_out = HTRANS_NONSEQ;
        HBURST_out = HBURST_SINGLE;
        tick();
        chk("incr_end_sel",  32'(port_sel),   2);
        chk("incr_end_hold", 32'(burst_hold), 0);

        // asynchronous reset in the middle of an INCR8
        HBURST_out = HBURST_INCR8;
        tick();
        chk("rstmid_b1_hold", 32'(burst_hold), 1);
        HTRANS_out = HTRANS_SEQ;
        tick();
        #1;
        HRESETn = 1'b0;
        #1;
        chk("rstmid_sel",   32'(port_sel),   0);
        chk("rstmid_nosel", 32'(port_nosel), 1);
        chk("rstmid_hold",  32'(burst_hold), 0);
        @(negedge HCLK);
        HRESETn    = 1'b1;
        req        = 3'b111;
        HTRANS_out = HTRANS_NONSEQ;
        HBURST_out = HBURST_SINGLE;

        // all ports requesting, SINGLE transfers only
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("single_seq_sel", 32'(port_sel), 32'(exp_seq[i]));
        end

        // no requests: grant drops, nosel follows HSEL_out
        req        = '0;
        HTRANS_out = HTRANS_IDLE;
        HSEL_out   = 1'b1;
        tick();
        chk("drop_sel",   32'(port_sel),   0);
        chk("drop_nosel", 32'(port_nosel), 0);
        HSEL_out = 1'b0;
        tick();
        chk("drop2_nosel", 32'(port_nosel), 1);
        chk("drop2_hold",  32'(burst_hold), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
